// File: rtl/mandelbrot_reorder.sv
// Reorder buffer for the Mandelbrot writeback path: pixels are tagged at issue,
// completed out of order by the iteration core, and released in issue order.
module mandelbrot_reorder #(
  parameter int DEPTH_LOG2 = 4,
  parameter int VW         = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_alloc_valid,
  output logic                  o_alloc_ready,
  input  logic [10:0]           i_alloc_x,
  input  logic [10:0]           i_alloc_y,
  output logic [DEPTH_LOG2-1:0] o_alloc_tag,
  input  logic                  i_done_valid,
  input  logic [DEPTH_LOG2-1:0] i_done_tag,
  input  logic [VW-1:0]         i_done_v,
  output logic                  o_out_valid,
  input  logic                  i_out_ready,
  output logic [10:0]           o_xout,
  output logic [10:0]           o_yout,
  output logic [VW-1:0]         o_v,
  output logic [DEPTH_LOG2:0]   o_count,
  output logic                  o_err
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2 + 1;

  typedef enum logic [1:0] {
    ST_FREE = 2'd0,
    ST_PEND = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e          r_state [DEPTH];
  logic [10:0]     r_x     [DEPTH];
  logic [10:0]     r_y     [DEPTH];
  logic [VW-1:0]   r_v     [DEPTH];
  logic [PW-1:0]   r_head;
  logic [PW-1:0]   r_tail;
  logic [PW-1:0]   r_count;
  logic            r_err;

  logic [DEPTH_LOG2-1:0] w_head_idx;
  logic [DEPTH_LOG2-1:0] w_tail_idx;
  logic                  w_alloc_fire;
  logic                  w_done_ok;
  logic                  w_retire;

  assign w_head_idx = r_head[DEPTH_LOG2-1:0];
  assign w_tail_idx = r_tail[DEPTH_LOG2-1:0];

  // Ready looks only at registered occupancy; a same-cycle retire does not free a slot early.
  assign o_alloc_ready = (r_count < PW'(DEPTH)) && !i_rst;
  assign o_alloc_tag   = w_tail_idx;
  assign w_alloc_fire  = i_alloc_valid && o_alloc_ready;

  assign w_done_ok     = (r_state[i_done_tag] == ST_PEND);

  assign o_out_valid   = (r_state[w_head_idx] == ST_DONE);
  assign w_retire      = o_out_valid && i_out_ready;
  assign o_xout        = o_out_valid ? r_x[w_head_idx] : '0;
  assign o_yout        = o_out_valid ? r_y[w_head_idx] : '0;
  assign o_v           = o_out_valid ? r_v[w_head_idx] : '0;
  assign o_count       = r_count;
  assign o_err         = r_err;

  // Alloc, complete and retire touch disjoint entries (FREE / PENDING / DONE),
  // so their writes into the entry arrays never collide.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_state[i] <= ST_FREE;
        r_x[i]     <= '0;
        r_y[i]     <= '0;
        r_v[i]     <= '0;
      end
    end else begin
      if (w_alloc_fire) begin
        r_x[w_tail_idx]     <= i_alloc_x;
        r_y[w_tail_idx]     <= i_alloc_y;
        r_state[w_tail_idx] <= ST_PEND;
        r_tail              <= r_tail + 1'b1;
      end
      if (i_done_valid) begin
        if (w_done_ok) begin
          r_v[i_done_tag]     <= i_done_v;
          r_state[i_done_tag] <= ST_DONE;
        end else begin
          r_err <= 1'b1;
        end
      end
      if (w_retire) begin
        r_state[w_head_idx] <= ST_FREE;
        r_head              <= r_head + 1'b1;
      end
      r_count <= r_count + PW'(w_alloc_fire) - PW'(w_retire);
    end
  end

endmodule

// File: tb/tb_mandelbrot_reorder.sv
// Bench for mandelbrot_reorder: directed scenarios then random traffic, checked
// every cycle against an in-order queue model of the outstanding pixels.
module tb_mandelbrot_reorder;
  localparam int DL = 4;
  localparam int VW = 32;
  localparam int D  = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          alloc_valid, alloc_ready;
  logic [10:0]   alloc_x, alloc_y;
  logic [DL-1:0] alloc_tag;
  logic          done_valid;
  logic [DL-1:0] done_tag;
  logic [VW-1:0] done_v;
  logic          out_valid, out_ready;
  logic [10:0]   xout, yout;
  logic [VW-1:0] v;
  logic [DL:0]   count;
  logic          err;

  always #5 clk = ~clk;

  mandelbrot_reorder #(.DEPTH_LOG2(DL), .VW(VW)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_alloc_valid(alloc_valid), .o_alloc_ready(alloc_ready),
    .i_alloc_x(alloc_x), .i_alloc_y(alloc_y), .o_alloc_tag(alloc_tag),
    .i_done_valid(done_valid), .i_done_tag(done_tag), .i_done_v(done_v),
    .o_out_valid(out_valid), .i_out_ready(out_ready),
    .o_xout(xout), .o_yout(yout), .o_v(v),
    .o_count(count), .o_err(err)
  );

  // Model: outstanding pixels in allocation order; q[k] owns tag (base+k)%D.
  typedef struct {
    logic [10:0]   x;
    logic [10:0]   y;
    logic [VW-1:0] v;
    bit            done;
  } ent_t;

  ent_t q[$];
  int   base;
  bit   merr;
  bit   chk_en;
  int   tests;
  int   fails;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit exp_ov();
    return q.size() > 0 && q[0].done;
  endfunction

  task automatic check_all();
    chk("alloc_ready", 64'(alloc_ready), 64'(q.size() < D && !rst));
    chk("alloc_tag",   64'(alloc_tag),   64'((base + q.size()) % D));
    chk("out_valid",   64'(out_valid),   64'(exp_ov()));
    chk("xout",        64'(xout),        exp_ov() ? 64'(q[0].x) : 64'd0);
    chk("yout",        64'(yout),        exp_ov() ? 64'(q[0].y) : 64'd0);
    chk("v",           64'(v),           exp_ov() ? 64'(q[0].v) : 64'd0);
    chk("count",       64'(count),       64'(q.size()));
    chk("err",         64'(err),         64'(merr));
  endtask

  // One clock: check current outputs, then advance the model across the edge.
  task automatic cyc();
    bit a, r, dv;
    int dt;
    logic [VW-1:0] dval;
    logic [10:0] ax, ay;
    #2;
    if (chk_en) check_all();
    a    = alloc_valid && q.size() < D && !rst;
    r    = exp_ov() && out_ready;
    dv   = done_valid;
    dt   = int'(done_tag);
    dval = done_v;
    ax   = alloc_x;
    ay   = alloc_y;
    @(posedge clk);
    if (rst) begin
      q.delete();
      base = 0;
      merr = 0;
    end else begin
      if (dv) begin
        int k = (dt - base + D) % D;
        if (k < q.size() && !q[k].done) begin
          q[k].v    = dval;
          q[k].done = 1;
        end else begin
          merr = 1;
        end
      end
      if (r) begin
        void'(q.pop_front());
        base = (base + 1) % D;
      end
      if (a) begin
        ent_t e;
        e.x = ax; e.y = ay; e.v = '0; e.done = 0;
        q.push_back(e);
      end
    end
    #1;
  endtask

  task automatic alloc1(input int x, input int y);
    alloc_valid = 1; alloc_x = 11'(x); alloc_y = 11'(y);
    cyc();
    alloc_valid = 0;
  endtask

  task automatic done1(input int t, input int val);
    done_valid = 1; done_tag = DL'(t); done_v = VW'(val);
    cyc();
    done_valid = 0;
  endtask

  task automatic reset1();
    rst = 1;
    cyc();
    rst = 0;
  endtask

  int t;
  int pend[$];

  initial begin
    tests = 0; fails = 0; chk_en = 0; base = 0; merr = 0;
    rst = 1; alloc_valid = 0; alloc_x = 0; alloc_y = 0;
    done_valid = 0; done_tag = 0; done_v = 0; out_ready = 1;
    cyc();
    chk_en = 1;
    rst = 0;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_alloc_tag", 64'(alloc_tag), 64'd0);

    // In-order completion
    alloc1(0, 0); alloc1(1, 0); alloc1(2, 0);
    done1(0, 5);
    chk("inord_v0", 64'(v), 64'd5);
    chk("inord_x0", 64'(xout), 64'd0);
    done1(1, 7);
    chk("inord_v1", 64'(v), 64'd7);
    chk("inord_x1", 64'(xout), 64'd1);
    done1(2, 9);
    chk("inord_v2", 64'(v), 64'd9);
    chk("inord_x2", 64'(xout), 64'd2);
    cyc();
    chk("inord_count", 64'(count), 64'd0);

    // Out-of-order completion: tags 3,4,5
    alloc1(10, 1); alloc1(11, 1); alloc1(12, 1);
    done1(5, 9);
    done1(4, 7);
    chk("ooo_hold", 64'(out_valid), 64'd0);
    done1(3, 5);
    chk("ooo_v0", 64'(v), 64'd5);
    cyc();
    chk("ooo_v1", 64'(v), 64'd7);
    cyc();
    chk("ooo_v2", 64'(v), 64'd9);
    cyc();
    chk("ooo_count", 64'(count), 64'd0);

    // Full and wrap
    reset1();
    for (int i = 0; i < D; i++) alloc1(i, 2);
    chk("full_count", 64'(count), 64'd16);
    chk("full_ready", 64'(alloc_ready), 64'd0);
    alloc_valid = 1; alloc_x = 11'd99; alloc_y = 11'd3;
    cyc();
    chk("full_held", 64'(count), 64'd16);
    done_valid = 1; done_tag = 0; done_v = 32'd42;
    cyc();
    done_valid = 0;
    chk("full_head_valid", 64'(out_valid), 64'd1);
    chk("full_head_v", 64'(v), 64'd42);
    cyc();
    chk("wrap_ready", 64'(alloc_ready), 64'd1);
    chk("wrap_tag", 64'(alloc_tag), 64'd0);
    cyc();
    alloc_valid = 0;
    chk("wrap_count", 64'(count), 64'd16);
    for (int i = D - 1; i >= 0; i--) done1(i, 100 + i);
    repeat (20) cyc();
    chk("wrap_drain", 64'(count), 64'd0);

    // Backpressure
    t = int'(alloc_tag);
    alloc1(7, 8);
    out_ready = 0;
    done1(t, 32'hABCD);
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_v", 64'(v), 64'hABCD);
      chk("bp_x", 64'(xout), 64'd7);
    end
    out_ready = 1;
    cyc();
    chk("bp_retire", 64'(count), 64'd0);
    chk("bp_after", 64'(out_valid), 64'd0);

    // Protocol errors
    done1(3, 1234);
    chk("perr_err", 64'(err), 64'd1);
    chk("perr_count", 64'(count), 64'd0);
    chk("perr_valid", 64'(out_valid), 64'd0);
    t = int'(alloc_tag);
    alloc1(5, 6);
    out_ready = 0;
    done1(t, 11);
    done1(t, 22);
    chk("perr_sticky", 64'(err), 64'd1);
    chk("perr_keep_v", 64'(v), 64'd11);
    out_ready = 1;
    cyc();

    // Reset mid-operation
    for (int i = 0; i < 5; i++) alloc1(20 + i, 4);
    reset1();
    chk("mrst_count", 64'(count), 64'd0);
    chk("mrst_valid", 64'(out_valid), 64'd0);
    chk("mrst_err", 64'(err), 64'd0);
    chk("mrst_tag", 64'(alloc_tag), 64'd0);
    done1(2, 77);
    chk("mrst_late", 64'(err), 64'd1);
    reset1();

    // Random traffic
    for (int n = 0; n < 2000; n++) begin
      alloc_valid = 1'($urandom);
      alloc_x     = 11'($urandom);
      alloc_y     = 11'($urandom);
      out_ready   = ($urandom % 4) != 0;
      pend.delete();
      foreach (q[k]) if (!q[k].done) pend.push_back((base + k) % D);
      done_valid = 0;
      if (pend.size() > 0 && ($urandom % 3) != 0) begin
        done_valid = 1;
        done_tag   = DL'(pend[$urandom % pend.size()]);
      end else if (($urandom % 50) == 0) begin
        done_valid = 1;
        done_tag   = DL'($urandom);
      end
      done_v = $urandom;
      cyc();
    end
    alloc_valid = 0; done_valid = 0; out_ready = 1;
    repeat (3) cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
